rate_recovery: RTL and testbench
================================

Name: rate_recovery

Overview:
- Front end of the clks_alot recovery path. Samples an incoming, already-synchronized clock and detects its rising and falling edges.
- Measures the high and low half-periods in sys clock cycles, and declares lock-in once both measurements are stable within a drift window.
- Outputs feed the generation stage: recovered events, high/low rates and fully-locked status.

Parameters:
- LOCK_COUNT, 2: consecutive in-window re-measurements each phase needs before it is locked (range 1..15).
- DRIFT_WINDOW, 1: maximum |measured - held rate| still treated as a match.

Ports:
- sys_dom_i  input  common_p::clk_dom_s  carries clk and rst. Single clock; reset is synchronous and active-high.
- recovery_en_i  input  1  enables recovery. While low, the block is held in the cleared state.
- clear_state_i  input  1  synchronous clear of all state, same effect as reset.
- sense_clk_i  input  1  incoming clock, already synchronized to sys clk.
- recovered_events_o  output  clks_alot_p::recovered_events_s  registered rise/fall/any-edge pulses.
- high_rate_o  output  RATE_COUNTER_WIDTH  held high half-period in cycles.
- low_rate_o  output  RATE_COUNTER_WIDTH  held low half-period in cycles.
- high_locked_o  output  1  high phase locked.
- low_locked_o  output  1  low phase locked.
- fully_locked_in_o  output  1  high_locked_o & low_locked_o.
- drift_violation_o  output  1  one-cycle pulse: a locked phase measured out of window.
- stall_violation_o  output  1  one-cycle pulse: half-period counter saturated with no edge.

Behaviour:
- Reset / clear / enable low: every output is 0, sample register is 0, counter is 0, FSM goes to IDLE. Clear has priority over any edge in the same cycle.
- Edge detect: prev <= sense_clk_i each cycle. rise = cur & ~prev; fall = ~cur & prev. The first enabled cycle only loads prev, so no edge is reported.
- FSM states: IDLE, MEASURE.
  - IDLE -> MEASURE on the first edge. No measurement is taken in this transition.
  - MEASURE -> IDLE on stall or clear.
- Counter: on an edge cycle the counter loads 1. Otherwise, in MEASURE, it increments by 1 and saturates at all-ones.
- Measurement: at an edge in MEASURE, measured = counter value before the reload.
  - A fall measures the high half-period; a rise measures the low half-period.
  - Example: edges at cycles 10 and 14 give measured = 4.
- Per-phase tracker, updated only on its own edge:
  - First measurement since clear: load the rate, match_cnt = 0.
  - Measurement within DRIFT_WINDOW of the held rate: match_cnt++, saturating at LOCK_COUNT. While locked, the held rate is not updated.
  - Measurement outside the window: load the new rate, set match_cnt = 0, drop lock. If the phase was locked, pulse drift_violation_o.
  - locked = (match_cnt == LOCK_COUNT).
- Latency: events, rates, locks and violations are all registered and appear 1 cycle after the sampled edge cycle.
- Stall: if the counter is at all-ones in a non-edge cycle, pulse stall_violation_o once, clear both trackers and return to IDLE.
- Stall boundary: an edge arriving in the same cycle as saturation wins; it is measured as all-ones and no stall is raised.
- Width: the window comparison uses an unsigned absolute difference computed at RATE_COUNTER_WIDTH+1 bits, so there is no wrap.
- Minimum measurable half-period is 1.
- fully_locked_in_o falls in the cycle after either phase unlocks. The generation stage re-syncs on that fall.

Decomposition:
- clks_alot_p (shared package):
  - RATE_COUNTER_WIDTH
  - recovered_events_s {rise, fall, any}
  - recovery_state_e {IDLE, MEASURE}
- Sub-module half_rate_tracker, instantiated twice (high, low).
  - Inputs: measure strobe, measured value, clear.
  - Outputs: rate, locked, drift pulse.

Test Plan:
- Stable 4/4 clock, first rise at cycle 10, LOCK_COUNT=2, DRIFT_WINDOW=1 -> high_rate_o = 4 at cycle 15, low_rate_o = 4 at cycle 19; high_locked_o at cycle 31; fully_locked_in_o at cycle 35.
- After lock, one high phase of 5 -> no violation, high_rate_o stays 4, lock held. Then one high phase of 7 -> drift_violation_o pulse, high_rate_o = 7, fully_locked_in_o = 0 the next cycle.
- Uneven 4 high / 3 low -> high_rate_o = 4, low_rate_o = 3, both locked after 3 measurements each.
- sense_clk_i held constant after lock with RATE_COUNTER_WIDTH=4 -> stall_violation_o pulses once after 15 cycles; rates = 0; FSM in IDLE; the next edge produces no measurement.
- clear_state_i asserted in the same cycle as a rise -> no event reported, all outputs 0 the next cycle.
- recovery_en_i low for 5 cycles mid-lock, then high -> outputs 0 during and after; relock requires 3 fresh measurements per phase.

Source files
------------

// File: rtl/rate_recovery_pkg.sv
// Shared types for the clock rate recovery front end.
// Pure declarations, no logic; imported by every file of the block.
package rate_recovery_pkg;

  localparam int RATE_COUNTER_WIDTH = 4;

  typedef logic [RATE_COUNTER_WIDTH-1:0] rate_t;
  typedef logic [RATE_COUNTER_WIDTH:0]   diff_t;

  localparam rate_t RATE_MAX = '1;

  typedef struct packed {
    logic rise;
    logic fall;
    logic any;
  } recovered_events_s;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } recovery_state_e;

  // One extra bit keeps the subtraction from wrapping
  function automatic diff_t abs_diff(input rate_t a, input rate_t b);
    diff_t ea;
    diff_t eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return (ea >= eb) ? (ea - eb) : (eb - ea);
  endfunction

endpackage

// File: rtl/rate_recovery_if.sv
// Control inputs and recovered-rate outputs of the rate recovery block.
// master: the recovery block; slave: the driving/consuming generation side.
interface rate_recovery_if;
  import rate_recovery_pkg::*;

  logic              recovery_en_i;
  logic              clear_state_i;
  logic              sense_clk_i;
  recovered_events_s recovered_events_o;
  rate_t             high_rate_o;
  rate_t             low_rate_o;
  logic              high_locked_o;
  logic              low_locked_o;
  logic              fully_locked_in_o;
  logic              drift_violation_o;
  logic              stall_violation_o;

  modport master (
    input  recovery_en_i,
    input  clear_state_i,
    input  sense_clk_i,
    output recovered_events_o,
    output high_rate_o,
    output low_rate_o,
    output high_locked_o,
    output low_locked_o,
    output fully_locked_in_o,
    output drift_violation_o,
    output stall_violation_o
  );

  modport slave (
    output recovery_en_i,
    output clear_state_i,
    output sense_clk_i,
    input  recovered_events_o,
    input  high_rate_o,
    input  low_rate_o,
    input  high_locked_o,
    input  low_locked_o,
    input  fully_locked_in_o,
    input  drift_violation_o,
    input  stall_violation_o
  );

endinterface

// File: rtl/rate_recovery_half_rate_tracker.sv
// Holds one half-period rate and counts consecutive in-window re-measurements to lock.
// Rate/lock/drift registered, 1 cycle after measure_i; clear_i overrides a measurement.
module rate_recovery_half_rate_tracker
  import rate_recovery_pkg::*;
#(
  parameter int LOCK_COUNT   = 2,
  parameter int DRIFT_WINDOW = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  clear_i,
  input  logic  measure_i,
  input  rate_t measured_i,
  output rate_t rate_o,
  output logic  locked_o,
  output logic  drift_o
);

  typedef logic [3:0] match_t;

  localparam match_t LOCK_MATCH = match_t'(LOCK_COUNT);
  localparam diff_t  WINDOW     = diff_t'(DRIFT_WINDOW);

  rate_t  rate_q, rate_d;
  match_t match_q, match_d;
  logic   vld_q, vld_d;
  logic   drift_q, drift_d;

  logic locked;
  logic in_window;

  assign locked    = (match_q == LOCK_MATCH);
  assign in_window = (abs_diff(measured_i, rate_q) <= WINDOW);

  always_comb begin
    rate_d  = rate_q;
    match_d = match_q;
    vld_d   = vld_q;
    drift_d = 1'b0;
    if (clear_i) begin
      rate_d  = '0;
      match_d = '0;
      vld_d   = 1'b0;
    end else if (measure_i) begin
      if (!vld_q) begin
        rate_d  = measured_i;
        match_d = '0;
        vld_d   = 1'b1;
      end else if (in_window) begin
        // Once locked the held rate is frozen so small jitter cannot walk it away
        if (!locked) begin
          rate_d  = measured_i;
          match_d = match_q + 1'b1;
        end
      end else begin
        rate_d  = measured_i;
        match_d = '0;
        drift_d = locked;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rate_q  <= '0;
      match_q <= '0;
      vld_q   <= 1'b0;
      drift_q <= 1'b0;
    end else begin
      rate_q  <= rate_d;
      match_q <= match_d;
      vld_q   <= vld_d;
      drift_q <= drift_d;
    end
  end

  assign rate_o   = rate_q;
  assign locked_o = locked;
  assign drift_o  = drift_q;

endmodule

// File: rtl/rate_recovery.sv
// Detects sense clock edges, measures high/low half-periods and reports lock status.
// All outputs registered, 1 cycle after the sampled edge; no backpressure, events are pulses.
module rate_recovery
  import rate_recovery_pkg::*;
#(
  parameter int LOCK_COUNT   = 2,
  parameter int DRIFT_WINDOW = 1
) (
  input  logic            clk,
  input  logic            rst,
  rate_recovery_if.master rr
);

  recovery_state_e   state_q, state_d;
  rate_t             cnt_q, cnt_d;
  logic              prev_q, prev_d;
  logic              primed_q, primed_d;
  recovered_events_s events_q, events_d;
  logic              stall_q, stall_d;

  logic  hold;
  logic  rise;
  logic  fall;
  logic  any_edge;
  logic  cnt_sat;
  logic  measure_en;
  logic  stall;
  rate_t high_rate, low_rate;
  logic  high_locked, low_locked;
  logic  high_drift, low_drift;

  assign hold     = rr.clear_state_i | ~rr.recovery_en_i;
  // primed_q masks the first enabled cycle, where prev_q still holds the cleared value
  assign rise     = primed_q &  rr.sense_clk_i & ~prev_q;
  assign fall     = primed_q & ~rr.sense_clk_i &  prev_q;
  assign any_edge = rise | fall;
  assign cnt_sat  = (cnt_q == RATE_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_edge) state_d = MEASURE;
      MEASURE: if (stall)    state_d = IDLE;
      default:               state_d = IDLE;
    endcase
    if (hold) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    measure_en = 1'b0;
    stall      = 1'b0;
    case (state_q)
      MEASURE: begin
        measure_en = any_edge;
        stall      = ~any_edge & cnt_sat;
      end
      default: begin
        measure_en = 1'b0;
        stall      = 1'b0;
      end
    endcase
  end

  always_comb begin
    prev_d        = rr.sense_clk_i;
    primed_d      = 1'b1;
    events_d      = '0;
    events_d.rise = rise;
    events_d.fall = fall;
    events_d.any  = any_edge;
    stall_d       = stall;
    cnt_d         = cnt_q;
    // An edge on the saturating cycle reloads here and is measured as all-ones
    if (any_edge) begin
      cnt_d = rate_t'(1);
    end else if (stall) begin
      cnt_d = '0;
    end else if ((state_q == MEASURE) && !cnt_sat) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (hold) begin
      prev_d   = 1'b0;
      primed_d = 1'b0;
      events_d = '0;
      stall_d  = 1'b0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      prev_q   <= 1'b0;
      primed_q <= 1'b0;
      events_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      primed_q <= primed_d;
      events_q <= events_d;
      stall_q  <= stall_d;
    end
  end

  // A fall closes the high half-period, a rise closes the low one
  rate_recovery_half_rate_tracker #(
    .LOCK_COUNT   (LOCK_COUNT),
    .DRIFT_WINDOW (DRIFT_WINDOW)
  ) u_high (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (hold | stall),
    .measure_i  (measure_en & fall),
    .measured_i (cnt_q),
    .rate_o     (high_rate),
    .locked_o   (high_locked),
    .drift_o    (high_drift)
  );

  rate_recovery_half_rate_tracker #(
    .LOCK_COUNT   (LOCK_COUNT),
    .DRIFT_WINDOW (DRIFT_WINDOW)
  ) u_low (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (hold | stall),
    .measure_i  (measure_en & rise),
    .measured_i (cnt_q),
    .rate_o     (low_rate),
    .locked_o   (low_locked),
    .drift_o    (low_drift)
  );

  assign rr.recovered_events_o = events_q;
  assign rr.high_rate_o        = high_rate;
  assign rr.low_rate_o         = low_rate;
  assign rr.high_locked_o      = high_locked;
  assign rr.low_locked_o       = low_locked;
  assign rr.fully_locked_in_o  = high_locked & low_locked;
  assign rr.drift_violation_o  = high_drift | low_drift;
  assign rr.stall_violation_o  = stall_q;

endmodule

// File: tb/tb_rate_recovery.sv
// Scoreboard bench for rate_recovery: a timestamp-based reference pushes the expected
// output word for every driven cycle, popped and compared once the DUT has clocked it.
module tb_rate_recovery;
  import rate_recovery_pkg::*;

  localparam int LOCK = 2;
  localparam int WIN  = 1;
  localparam int RMAX = (1 << RATE_COUNTER_WIDTH) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rate_recovery_if rr ();

  rate_recovery #(
    .LOCK_COUNT   (LOCK),
    .DRIFT_WINDOW (WIN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rr  (rr)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] sb_q[$];

  bit m_primed, m_prev, m_meas;
  int m_last;
  bit m_vld[2];
  int m_rate[2];
  int m_match[2];

  logic [15:0]       obs;
  recovered_events_s obs_ev;
  logic [3:0]        obs_hr, obs_lr;
  logic              obs_hl, obs_ll, obs_fl, obs_dv, obs_sv;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  function automatic bit m_locked(input int p);
    return m_vld[p] && (m_match[p] == LOCK);
  endfunction

  task automatic model_clear_trk();
    for (int p = 0; p < 2; p++) begin
      m_vld[p]   = 1'b0;
      m_rate[p]  = 0;
      m_match[p] = 0;
    end
  endtask

  task automatic model_track(input int p, input int m, output bit drift);
    int d;
    bit lk;
    drift = 1'b0;
    lk    = m_locked(p);
    d     = (m > m_rate[p]) ? (m - m_rate[p]) : (m_rate[p] - m);
    if (!m_vld[p]) begin
      m_vld[p]   = 1'b1;
      m_rate[p]  = m;
      m_match[p] = 0;
    end else if (d <= WIN) begin
      if (!lk) begin
        m_rate[p] = m;
        m_match[p]++;
      end
    end else begin
      drift      = lk;
      m_rate[p]  = m;
      m_match[p] = 0;
    end
  endtask

  task automatic step(input bit en, input bit clr, input bit s);
    bit e, r, f, dv, sv;
    int age;
    recovered_events_s ev;
    logic [15:0] exp_w;
    rr.recovery_en_i = en;
    rr.clear_state_i = clr;
    rr.sense_clk_i   = s;
    ev = '0;
    dv = 1'b0;
    sv = 1'b0;
    if (rst || clr || !en) begin
      m_primed = 1'b0;
      m_prev   = 1'b0;
      m_meas   = 1'b0;
      m_last   = 0;
      model_clear_trk();
    end else begin
      e   = m_primed && (s != m_prev);
      r   = e && s;
      f   = e && !s;
      age = cyc - m_last;
      if (e) begin
        if (m_meas) model_track(f ? 0 : 1, (age > RMAX) ? RMAX : age, dv);
        m_meas = 1'b1;
        m_last = cyc;
      end else if (m_meas && age >= RMAX) begin
        sv     = 1'b1;
        m_meas = 1'b0;
        model_clear_trk();
      end
      m_prev   = s;
      m_primed = 1'b1;
      ev.rise  = r;
      ev.fall  = f;
      ev.any   = e;
    end
    sb_q.push_back({ev, rate_t'(m_rate[0]), rate_t'(m_rate[1]), m_locked(0), m_locked(1),
                    m_locked(0) && m_locked(1), dv, sv});
    @(posedge clk);
    @(negedge clk);
    cyc++;
    obs_ev = rr.recovered_events_o;
    obs_hr = rr.high_rate_o;
    obs_lr = rr.low_rate_o;
    obs_hl = rr.high_locked_o;
    obs_ll = rr.low_locked_o;
    obs_fl = rr.fully_locked_in_o;
    obs_dv = rr.drift_violation_o;
    obs_sv = rr.stall_violation_o;
    obs    = {obs_ev, obs_hr, obs_lr, obs_hl, obs_ll, obs_fl, obs_dv, obs_sv};
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      exp_w = sb_q.pop_front();
      check("sb", {16'd0, obs}, {16'd0, exp_w});
    end
  endtask

  task automatic half(input bit level, input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, level);
  endtask

  task automatic period(input int h, input int l);
    half(1'b1, h);
    half(1'b0, l);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nst;
    bit s;

    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("reset_state", {16'd0, obs}, 32'd0);
    rst = 1'b0;

    // Stable 4/4, first rise on enabled cycle 10; obs after step k is cycle k+1
    for (int k = 0; k < 42; k++) begin
      s = (k >= 10) && (((k - 10) % 8) < 4);
      step(1'b1, 1'b0, s);
      if (k == 9)  check("idle_quiet", {16'd0, obs}, 32'd0);
      if (k == 10) check("first_rise_ev", {29'd0, obs_ev}, 32'b101);
      if (k == 10) check("first_rise_nomeas", {28'd0, obs_hr}, 32'd0);
      if (k == 14) check("hr_c15", {28'd0, obs_hr}, 32'd4);
      if (k == 18) check("lr_c19", {28'd0, obs_lr}, 32'd4);
      if (k == 29) check("hl_c30", {31'd0, obs_hl}, 32'd0);
      if (k == 30) check("hl_c31", {31'd0, obs_hl}, 32'd1);
      if (k == 33) check("fl_c34", {31'd0, obs_fl}, 32'd0);
      if (k == 34) check("fl_c35", {31'd0, obs_fl}, 32'd1);
    end

    // Jitter of one stays locked; a jump of three is a drift
    half(1'b1, 5);
    half(1'b0, 1);
    check("jit_dv", {31'd0, obs_dv}, 32'd0);
    check("jit_hr", {28'd0, obs_hr}, 32'd4);
    check("jit_hl", {31'd0, obs_hl}, 32'd1);
    half(1'b0, 3);
    half(1'b1, 7);
    half(1'b0, 1);
    check("drift_dv", {31'd0, obs_dv}, 32'd1);
    check("drift_hr", {28'd0, obs_hr}, 32'd7);
    check("drift_fl", {31'd0, obs_fl}, 32'd0);
    half(1'b0, 3);
    check("drift_pulse_end", {31'd0, obs_dv}, 32'd0);

    // Uneven 4 high / 3 low
    step(1'b1, 1'b1, 1'b0);
    half(1'b0, 2);
    for (int p = 0; p < 4; p++) period(4, 3);
    check("uneven_hr", {28'd0, obs_hr}, 32'd4);
    check("uneven_lr", {28'd0, obs_lr}, 32'd3);
    check("uneven_fl", {31'd0, obs_fl}, 32'd1);

    // Hold the sense clock: one stall, trackers cleared, back to IDLE
    nst = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0, 1'b0);
      nst += int'(obs_sv);
    end
    check("stall_once", nst, 1);
    check("stall_rates", {24'd0, obs_hr, obs_lr}, 32'd0);
    check("stall_locks", {29'd0, obs_hl, obs_ll, obs_fl}, 32'd0);
    step(1'b1, 1'b0, 1'b1);
    check("post_stall_ev", {29'd0, obs_ev}, 32'b101);
    check("post_stall_nomeas", {24'd0, obs_hr, obs_lr}, 32'd0);
    half(1'b1, 3);
    half(1'b0, 1);
    check("post_stall_meas", {28'd0, obs_hr}, 32'd4);

    // Clear on the same cycle as a rise
    step(1'b1, 1'b1, 1'b1);
    check("clr_rise_ev", {29'd0, obs_ev}, 32'd0);
    check("clr_all", {16'd0, obs}, 32'd0);

    // Relock, then drop enable mid-lock
    half(1'b0, 2);
    for (int p = 0; p < 4; p++) period(4, 4);
    check("relock_fl", {31'd0, obs_fl}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, (i % 2) == 0);
      check("en_low", {16'd0, obs}, 32'd0);
    end
    half(1'b0, 2);
    check("en_back", {16'd0, obs}, 32'd0);
    period(4, 4);
    period(4, 4);
    check("en_partial_fl", {31'd0, obs_fl}, 32'd0);
    check("en_partial_hl", {31'd0, obs_hl}, 32'd0);
    period(4, 4);
    period(4, 4);
    check("en_relock_fl", {31'd0, obs_fl}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
